// File: rtl/ebi_bridge_if.sv
// Bus-side and FIFO-side signal bundle for the EBI bridge; the bridge sits on
// the slave modport, the MCU/FIFO environment on the master modport.
interface ebi_bridge_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 19,
    parameter int CMD_WORDS = 5,
    parameter int NUM_CH    = 2
);
    logic [DATA_W-1:0]           data_in;
    logic [DATA_W-1:0]           data_out;
    logic [ADDR_W-1:0]           addr;
    logic                        rd;
    logic                        wr;
    logic                        cs;
    logic [CMD_WORDS*DATA_W-1:0] cmd_fifo_data_in;
    logic                        cmd_fifo_wr_en;
    logic                        cmd_fifo_full;
    logic                        cmd_fifo_almost_full;
    logic [NUM_CH*DATA_W-1:0]    sample_fifo_data_out;
    logic [NUM_CH-1:0]           sample_fifo_rd_en;
    logic [NUM_CH-1:0]           sample_fifo_empty;
    logic                        irq;

    modport slave (
        input  data_in, addr, rd, wr, cs,
        input  cmd_fifo_full, cmd_fifo_almost_full,
        input  sample_fifo_data_out, sample_fifo_empty,
        output data_out, cmd_fifo_data_in, cmd_fifo_wr_en,
        output sample_fifo_rd_en, irq
    );

    modport master (
        output data_in, addr, rd, wr, cs,
        output cmd_fifo_full, cmd_fifo_almost_full,
        output sample_fifo_data_out, sample_fifo_empty,
        input  data_out, cmd_fifo_data_in, cmd_fifo_wr_en,
        input  sample_fifo_rd_en, irq
    );
endinterface

// File: rtl/ebi_bridge.sv
// EBI-to-FIFO bridge: assembles multi-word commands from bus writes, serves the
// sample FIFOs through per-channel prefetch registers, and raises maskable IRQs.
module ebi_bridge #(
    parameter int          DATA_W    = 16,
    parameter int          ADDR_W    = 19,
    parameter int          CMD_WORDS = 5,
    parameter int          NUM_CH    = 2,
    parameter logic [15:0] EMPTY_VAL = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst,
    ebi_bridge_if.slave bus
);
    localparam int CMD_BASE    = 3;
    localparam int SAMPLE_BASE = CMD_BASE + CMD_WORDS;
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IRQ_W       = 12;
    localparam int OVF_BIT     = 10;
    localparam int UNF_BIT     = 11;
    localparam logic [IRQ_W-1:0] IRQ_IMPL = IRQ_W'((1 << NUM_CH) - 1) | 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PUSH    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic                  acc_rd, acc_wr;
    logic                  hit_status, hit_mask, hit_pend;
    logic [CMD_WORDS-1:0]  cmd_hit;
    logic [NUM_CH-1:0]     smp_hit;
    logic [CH_W-1:0]       smp_idx;
    logic                  last_cmd_wr;
    logic                  smp_rd;

    logic                  rd_d_reg, rd_dd_reg, rd_done;
    logic [CH_W-1:0]       rd_ch_reg;

    logic                  cmd_push, ovf_set, unf_set, reg_wr, rd_enter, rd_release;
    logic [CMD_WORDS-1:0]  slot_we;
    logic [CMD_WORDS-1:0][DATA_W-1:0] slot_reg;

    logic [NUM_CH-1:0]     valid_reg, valid_d_reg, capture_reg, fill_req, in_rd_wait;
    logic [NUM_CH-1:0][DATA_W-1:0] pref_reg, fifo_word, smp_value;

    logic [IRQ_W-1:0]      mask_reg, pend_reg, pend_set, pend_clr;
    logic                  irq_reg;

    logic [DATA_W-1:0]     status;
    logic [DATA_W-1:0]     rd_value;
    logic [DATA_W-1:0]     data_out_reg;

    // ---------------- address decode ----------------
    assign acc_rd     = bus.cs & bus.rd;
    assign acc_wr     = bus.cs & bus.wr;
    assign hit_status = (bus.addr == ADDR_W'(0));
    assign hit_mask   = (bus.addr == ADDR_W'(1));
    assign hit_pend   = (bus.addr == ADDR_W'(2));

    genvar gi;
    generate
        for (gi = 0; gi < CMD_WORDS; gi++) begin : g_cmd_dec
            assign cmd_hit[gi] = (bus.addr == ADDR_W'(CMD_BASE + gi));
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_smp_dec
            assign smp_hit[gi] = (bus.addr == ADDR_W'(SAMPLE_BASE + gi));
        end
    endgenerate

    assign last_cmd_wr = acc_wr & cmd_hit[CMD_WORDS-1];
    assign smp_rd      = acc_rd & (|smp_hit);

    always_comb begin
        smp_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (smp_hit[i]) begin
                smp_idx = CH_W'(i);
            end
        end
    end

    // Read completion is the falling edge of cs&rd seen two flops downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d_reg  <= 1'b0;
            rd_dd_reg <= 1'b0;
        end else begin
            rd_d_reg  <= acc_rd;
            rd_dd_reg <= rd_d_reg;
        end
    end
    assign rd_done = rd_dd_reg & ~rd_d_reg;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    state_next = ST_FETCH;
            ST_FETCH: begin
                if (last_cmd_wr) begin
                    state_next = ST_PUSH;
                end else if (smp_rd) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_PUSH:    state_next = ST_WAIT;
            ST_WAIT: begin
                if (!bus.rd && !bus.wr) begin
                    state_next = ST_FETCH;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) begin
                    state_next = ST_FETCH;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_push   = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        reg_wr     = 1'b0;
        rd_enter   = 1'b0;
        rd_release = 1'b0;
        slot_we    = '0;
        case (state_reg)
            ST_FETCH: begin
                reg_wr = acc_wr;
                if (acc_wr) begin
                    slot_we = cmd_hit;
                end
                if (!last_cmd_wr && smp_rd) begin
                    rd_enter = 1'b1;
                    unf_set  = ~(|(valid_reg & smp_hit));
                end
            end
            ST_PUSH: begin
                // A full FIFO drops the command but keeps the slots for a retry.
                cmd_push = !rst && !bus.cmd_fifo_full;
                ovf_set  = bus.cmd_fifo_full;
            end
            ST_RD_WAIT: rd_release = rd_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ch_reg <= '0;
        end else if (rd_enter) begin
            rd_ch_reg <= smp_idx;
        end
    end

    assign bus.cmd_fifo_wr_en = cmd_push;

    // ---------------- command word assembly ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else begin
            for (int k = 0; k < CMD_WORDS; k++) begin
                if (slot_we[k]) begin
                    slot_reg[k] <= bus.data_in;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < CMD_WORDS; gi++) begin : g_cmd_pack
            assign bus.cmd_fifo_data_in[(CMD_WORDS-gi)*DATA_W-1 -: DATA_W] = slot_reg[gi];
        end
    endgenerate

    // ---------------- per-channel prefetch ----------------
    // valid rises the cycle after the pop; the FIFO word is only on its output
    // during that cycle, so reads bypass to it until it lands in pref_reg.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign in_rd_wait[gi] = (state_reg == ST_RD_WAIT) && (rd_ch_reg == CH_W'(gi));
            assign fill_req[gi]   = !rst && !valid_reg[gi] && !bus.sample_fifo_empty[gi]
                                    && !capture_reg[gi] && !in_rd_wait[gi];
            assign fifo_word[gi]  = bus.sample_fifo_data_out[gi*DATA_W +: DATA_W];
            assign smp_value[gi]  = capture_reg[gi] ? fifo_word[gi] : pref_reg[gi];
        end
    endgenerate

    assign bus.sample_fifo_rd_en = fill_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= '0;
            valid_d_reg <= '0;
            capture_reg <= '0;
            pref_reg    <= '0;
        end else begin
            valid_d_reg <= valid_reg;
            capture_reg <= fill_req;
            for (int c = 0; c < NUM_CH; c++) begin
                if (capture_reg[c]) begin
                    pref_reg[c] <= fifo_word[c];
                end
                if (fill_req[c]) begin
                    valid_reg[c] <= 1'b1;
                end else if (in_rd_wait[c] && rd_release) begin
                    valid_reg[c] <= 1'b0;
                end
            end
        end
    end

    // ---------------- interrupt controller ----------------
    always_comb begin
        pend_set                = '0;
        pend_set[NUM_CH-1:0]    = valid_reg & ~valid_d_reg;
        pend_set[OVF_BIT]       = ovf_set;
        pend_set[UNF_BIT]       = unf_set;
    end

    assign pend_clr = (reg_wr && hit_pend) ? (bus.data_in[IRQ_W-1:0] & IRQ_IMPL) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
            pend_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            if (reg_wr && hit_mask) begin
                mask_reg <= bus.data_in[IRQ_W-1:0] & IRQ_IMPL;
            end
            pend_reg <= (pend_reg & ~pend_clr) | pend_set;
            irq_reg  <= |(pend_reg & mask_reg);
        end
    end

    assign bus.irq = irq_reg;

    // ---------------- register read path ----------------
    always_comb begin
        status              = '0;
        status[NUM_CH-1:0]  = valid_reg;
        status[8]           = bus.cmd_fifo_full;
        status[9]           = bus.cmd_fifo_almost_full;
        status[OVF_BIT]     = pend_reg[OVF_BIT];
        status[UNF_BIT]     = pend_reg[UNF_BIT];
    end

    always_comb begin
        rd_value = '0;
        if (hit_status) begin
            rd_value = status;
        end else if (hit_mask) begin
            rd_value = DATA_W'(mask_reg);
        end else if (hit_pend) begin
            rd_value = DATA_W'(pend_reg);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (smp_hit[c]) begin
                rd_value = valid_reg[c] ? smp_value[c] : DATA_W'(EMPTY_VAL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg <= '0;
        end else if (acc_rd) begin
            data_out_reg <= rd_value;
        end
    end

    assign bus.data_out = data_out_reg;

endmodule

// File: tb/tb_ebi_bridge.sv
// Directed bench for ebi_bridge: command assembly, overflow, sample prefetch,
// underflow, interrupt latency/masking and mid-transaction reset.
module tb_ebi_bridge;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 19;
    localparam int CMD_WORDS = 5;
    localparam int NUM_CH    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ebi_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_WORDS(CMD_WORDS), .NUM_CH(NUM_CH)) bus ();

    ebi_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_WORDS(CMD_WORDS), .NUM_CH(NUM_CH),
                 .EMPTY_VAL(16'hDEAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Sample FIFO model: storage written by the stimulus, popped on rd_en.
    logic [15:0] fifo_mem [2][16];
    int          push_cnt [2] = '{0, 0};
    int          pop_cnt  [2] = '{0, 0};
    logic [15:0] fifo_q   [2] = '{16'h0, 16'h0};
    int          cmd_pushes   = 0;
    logic [79:0] cmd_last     = '0;
    int          cyc          = 0;
    int          rd0_cyc      = 0;
    int          irq_cyc      = 0;
    logic        irq_prev     = 1'b0;

    assign bus.sample_fifo_empty[0] = (pop_cnt[0] >= push_cnt[0]);
    assign bus.sample_fifo_empty[1] = (pop_cnt[1] >= push_cnt[1]);
    assign bus.sample_fifo_data_out = {fifo_q[1], fifo_q[0]};

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (bus.sample_fifo_rd_en[c]) begin
                fifo_q[c]  <= fifo_mem[c][pop_cnt[c] % 16];
                pop_cnt[c] <= pop_cnt[c] + 1;
            end
        end
        if (bus.cmd_fifo_wr_en) begin
            cmd_pushes <= cmd_pushes + 1;
            cmd_last   <= bus.cmd_fifo_data_in;
        end
        cyc <= cyc + 1;
        if (bus.sample_fifo_rd_en[0]) rd0_cyc <= cyc;
        if (bus.irq && !irq_prev) irq_cyc <= cyc;
        irq_prev <= bus.irq;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic fifo_push(input int c, input logic [15:0] v);
        fifo_mem[c][push_cnt[c]] = v;
        push_cnt[c] = push_cnt[c] + 1;
    endtask

    task automatic bus_write(input int a, input logic [15:0] d);
        bus.addr = ADDR_W'(a); bus.data_in = d; bus.cs = 1'b1; bus.wr = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic write_last(input logic [15:0] d, input logic exp_en);
        bus.addr = ADDR_W'(3 + CMD_WORDS - 1); bus.data_in = d; bus.cs = 1'b1; bus.wr = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr = 1'b0;
        check("cmd_wr_en_next_cycle", 80'(bus.cmd_fifo_wr_en), 80'(exp_en));
        @(negedge clk);
        check("cmd_wr_en_single", 80'(bus.cmd_fifo_wr_en), 80'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input int a, input logic [15:0] exp);
        logic [15:0] d;
        bus.addr = ADDR_W'(a); bus.cs = 1'b1; bus.rd = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0; bus.rd = 1'b0;
        d = bus.data_out;
        check(tag, 80'(d), 80'(exp));
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int p0, p1, c0;
        bus.addr = '0; bus.data_in = '0; bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.cmd_fifo_full = 1'b0; bus.cmd_fifo_almost_full = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out",  80'(bus.data_out), 80'd0);
        check("rst_cmd_wr_en", 80'(bus.cmd_fifo_wr_en), 80'd0);
        check("rst_rd_en",     80'(bus.sample_fifo_rd_en), 80'd0);
        check("rst_irq",       80'(bus.irq), 80'd0);
        check("rst_cmd_data",  80'(bus.cmd_fifo_data_in), 80'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Command assembly
        for (int k = 0; k < 4; k++) bus_write(3 + k, 16'(16'h1111 * (k + 1)));
        write_last(16'h5555, 1'b1);
        check("cmd_push_count", 80'(cmd_pushes), 80'd1);
        check("cmd_word", cmd_last, 80'h1111_2222_3333_4444_5555);
        read_check("status_idle", 0, 16'h0000);
        read_check("cmd_addr_reads_zero", 3, 16'h0000);
        read_check("unmapped_reads_zero", 100, 16'h0000);

        // Overflow with full FIFO
        for (int k = 0; k < 4; k++) bus_write(3 + k, 16'(16'h6666 + 16'h1111 * k));
        bus.cmd_fifo_full = 1'b1;
        write_last(16'hAAAA, 1'b0);
        check("ovf_no_push", 80'(cmd_pushes), 80'd1);
        check("ovf_slots_kept", 80'(bus.cmd_fifo_data_in), 80'h6666_7777_8888_9999_AAAA);
        bus.cmd_fifo_almost_full = 1'b1;
        read_check("status_ovf_full", 0, 16'h0700);
        bus.cmd_fifo_full = 1'b0; bus.cmd_fifo_almost_full = 1'b0;
        read_check("pend_ovf", 2, 16'h0400);
        bus_write(2, 16'h0400);
        read_check("status_ovf_cleared", 0, 16'h0000);
        read_check("pend_ovf_cleared", 2, 16'h0000);

        // Channel 1 reads through prefetch, then underflow
        fifo_push(1, 16'hA001);
        fifo_push(1, 16'hA002);
        repeat (6) @(negedge clk);
        check("ch1_first_prefetch_pops", 80'(pop_cnt[1]), 80'd1);
        read_check("ch1_read1", 9, 16'hA001);
        check("ch1_refill_pops", 80'(pop_cnt[1]), 80'd2);
        read_check("ch1_read2", 9, 16'hA002);
        read_check("ch1_read3_empty", 9, 16'hDEAD);
        check("ch1_total_pops", 80'(pop_cnt[1]), 80'd2);
        read_check("status_unf", 0, 16'h0800);
        read_check("pend_unf_ch1", 2, 16'h0802);
        bus_write(2, 16'h0FFF);
        read_check("pend_all_cleared", 2, 16'h0000);

        // Interrupt latency and masking
        bus_write(1, 16'h0001);
        read_check("mask_readback", 1, 16'h0001);
        check("irq_masked_idle", 80'(bus.irq), 80'd0);
        fifo_push(0, 16'hB001);
        repeat (8) @(negedge clk);
        check("irq_ch0", 80'(bus.irq), 80'd1);
        check("irq_latency", 80'(irq_cyc - rd0_cyc), 80'd3);
        bus_write(2, 16'h0001);
        check("irq_cleared", 80'(bus.irq), 80'd0);
        fifo_push(1, 16'hC001);
        repeat (8) @(negedge clk);
        check("irq_ch1_masked", 80'(bus.irq), 80'd0);
        read_check("pend_ch1_only", 2, 16'h0002);
        read_check("ch0_data", 8, 16'hB001);
        read_check("ch1_data", 9, 16'hC001);
        bus_write(2, 16'h0FFF);

        // Simultaneous fills
        p0 = pop_cnt[0]; p1 = pop_cnt[1];
        fifo_push(0, 16'hD000);
        fifo_push(1, 16'hD111);
        repeat (6) @(negedge clk);
        check("sim_pop_ch0", 80'(pop_cnt[0]), 80'(p0 + 1));
        check("sim_pop_ch1", 80'(pop_cnt[1]), 80'(p1 + 1));
        read_check("status_both_valid", 0, 16'h0003);
        read_check("sim_ch0_data", 8, 16'hD000);
        read_check("sim_ch1_data", 9, 16'hD111);

        // Reset during RD_WAIT
        fifo_push(1, 16'hE000);
        repeat (6) @(negedge clk);
        p1 = pop_cnt[1];
        bus.addr = ADDR_W'(9); bus.cs = 1'b1; bus.rd = 1'b1;
        repeat (3) @(negedge clk);
        check("held_read_data", 80'(bus.data_out), 80'h0000_0000_0000_0000_E000);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdwait_data_out", 80'(bus.data_out), 80'd0);
        check("rst_rdwait_irq",      80'(bus.irq), 80'd0);
        check("rst_rdwait_rd_en",    80'(bus.sample_fifo_rd_en), 80'd0);
        bus.cs = 1'b0; bus.rd = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_rdwait_no_pop", 80'(pop_cnt[1]), 80'(p1));
        read_check("rst_rdwait_status", 0, 16'h0000);

        // Reset mid-command, coinciding with the final word
        c0 = cmd_pushes;
        for (int k = 0; k < 4; k++) bus_write(3 + k, 16'(16'h7000 + k));
        bus.addr = ADDR_W'(3 + CMD_WORDS - 1); bus.data_in = 16'h7004; bus.cs = 1'b1; bus.wr = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_wr_en", 80'(bus.cmd_fifo_wr_en), 80'd0);
        check("rst_cmd_slots", 80'(bus.cmd_fifo_data_in), 80'd0);
        bus.cs = 1'b0; bus.wr = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_cmd_no_push", 80'(cmd_pushes), 80'(c0));
        check("rst_cmd_slots_after", 80'(bus.cmd_fifo_data_in), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ebi_bridge.md
# ebi_bridge

Parametrised EBI-to-FIFO bridge between the external bus (MCU memory interface) and the FPGA command/sample FIFOs. Assembles CMD_WORDS bus writes into one wide command word pushed to the command FIFO, and serves NUM_CH independent sample FIFOs through per-channel prefetch registers. Adds overflow/underflow detection and a maskable, write-1-to-clear interrupt controller.

## Interface
- DATA_W, 16: bus and sample word width (≥16)
- ADDR_W, 19: bus address width
- CMD_WORDS, 5: bus words per command (1..8)
- NUM_CH, 2: sample channels (1..8)
- EMPTY_VAL, 16'hDEAD: value returned for an empty-channel read (zero-extended to DATA_W)
- clk  in  1  clock; reset rst, synchronous, active-high
- rst  in  1  synchronous active-high reset
- data_in  in  DATA_W  bus write data
- data_out  out  DATA_W  registered bus read data
- addr  in  ADDR_W  bus word address
- rd, wr, cs  in  1 each  bus strobes, active-high, asynchronous to clk (synchronised externally)
- cmd_fifo_data_in  out  CMD_WORDS*DATA_W  assembled command; word k (address 3+k) in bits [(CMD_WORDS-k)*DATA_W-1 -: DATA_W]
- cmd_fifo_wr_en  out  1  one-cycle push strobe
- cmd_fifo_full, cmd_fifo_almost_full  in  1 each
- sample_fifo_data_out  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W], first-word-fall-through not assumed
- sample_fifo_rd_en  out  NUM_CH  one-cycle pop strobes
- sample_fifo_empty  in  NUM_CH
- irq  out  1  registered level interrupt

## Operation
- Address map: 0 STATUS (RO), 1 IRQ_MASK (RW), 2 IRQ_PEND (read; write-1-to-clear), 3..3+CMD_WORDS-1 CMD words (WO), 3+CMD_WORDS+c SAMPLE channel c (RO). Other addresses: writes ignored, reads return 0.
- STATUS: [NUM_CH-1:0] channel prefetch valid; [8] cmd_fifo_full; [9] cmd_fifo_almost_full; [10] overflow sticky; [11] underflow sticky; others 0. Stickies clear only by clearing the matching IRQ_PEND bit.
- IRQ_PEND bits: [NUM_CH-1:0] channel c valid rose 0→1; [10] overflow; [11] underflow. irq <= |(IRQ_PEND & IRQ_MASK).
- Control FSM: IDLE → FETCH after reset. FETCH: cs&wr to CMD address captures data_in into word slot; if last slot → PUSH. cs&rd to sample address c → RD_WAIT(c). Other accesses stay in FETCH (writes to 1/2 applied in that cycle). PUSH (1 cycle): if !cmd_fifo_full assert cmd_fifo_wr_en, else set overflow (command dropped, slots retained); → WAIT. WAIT: stays until !rd & !wr, then FETCH. RD_WAIT: waits for rd-done; then clears channel valid (if it was valid) → FETCH.
- rd-done: rd&cs registered twice (rd_d, rd_dd); done = rd_dd & ~rd_d.
- Read data: every cycle with cs&rd, data_out <= addressed value; sample read returns prefetch register if valid, else EMPTY_VAL and sets underflow (once per access, on entry to RD_WAIT).
- Prefetch engine per channel, independent of FSM: when valid=0, !sample_fifo_empty[c], no fill pending, and channel not in RD_WAIT → assert sample_fifo_rd_en[c]; next cycle capture data, valid=1.
- Reset: data_out=0, cmd_fifo_wr_en=0, sample_fifo_rd_en=0, irq=0, all slots/prefetch=0, valid=0, IRQ_MASK=0, IRQ_PEND=0, FSM=IDLE. Reset mid-transaction aborts it; no push or pop issued.

## Timing
- Last CMD write seen in FETCH at cycle n → cmd_fifo_wr_en high exactly cycle n+1, one cycle.
- Channel pop: rd_en cycle m, prefetch valid m+1, STATUS/IRQ_PEND reflect m+2, irq m+3.
- rd falls at cycle r → done at r+2, valid cleared r+3, refill rd_en earliest r+3.
- data_out lags addressed value by one cycle while cs&rd held.
- IRQ_PEND clear and new set in same cycle: set wins.

## Test plan
- Write 0x1111..0x5555 to addrs 3..7 (CMD_WORDS=5) → single wr_en pulse, cmd_fifo_data_in = 0x1111_2222_3333_4444_5555.
- cmd_fifo_full=1 during final write → no wr_en, STATUS[10]=1, IRQ_PEND[10]=1; write 0x400 to addr 2 → both clear.
- Channel 1 FIFO holds 0xA001,0xA002; three reads of addr 9 → 0xA001, 0xA002, 0xDEAD with STATUS[11]=1, exactly two rd_en[1] pulses.
- IRQ_MASK=0x001, channel 0 fills → irq rises 3 cycles after rd_en[0]; channel 1 fills → irq unaffected.
- Simultaneous fills on channels 0 and 1 → independent rd_en, correct per-channel data.
- Assert rst during RD_WAIT and mid-command → all outputs reset values, no push/pop afterwards.
